// File: rtl/mc_pkg.sv
// mc_pkg: shared encodings for the multi-cycle control FSM and its instruction decoder.
package mc_pkg;

   // FSM states; encoding is visible on the state output port
   typedef enum logic [2:0] {
      StFetch  = 3'd0,
      StDecode = 3'd1,
      StExec   = 3'd2,
      StMem    = 3'd3,
      StWb     = 3'd4
   } state_e;

   // Opcodes, IR[31:26]
   localparam logic [5:0] OpSpecial = 6'b000000;
   localparam logic [5:0] OpOri     = 6'b001101;
   localparam logic [5:0] OpLw      = 6'b100011;
   localparam logic [5:0] OpSw      = 6'b101011;
   localparam logic [5:0] OpBeq     = 6'b000100;
   localparam logic [5:0] OpLui     = 6'b001111;
   localparam logic [5:0] OpJ       = 6'b000010;
   localparam logic [5:0] OpJal     = 6'b000011;
   localparam logic [5:0] OpLb      = 6'b100000;
   localparam logic [5:0] OpLh      = 6'b100001;
   localparam logic [5:0] OpSb      = 6'b101000;
   localparam logic [5:0] OpSh      = 6'b101001;
   localparam logic [5:0] OpBltzal  = 6'b000001;

   // Function codes for SPECIAL, IR[5:0]
   localparam logic [5:0] FnAdd = 6'b100000;
   localparam logic [5:0] FnSub = 6'b100010;
   localparam logic [5:0] FnJr  = 6'b001000;

   // Next-PC select
   localparam logic [1:0] NpcPc4    = 2'b00;
   localparam logic [1:0] NpcBranch = 2'b01;
   localparam logic [1:0] NpcJump   = 2'b10;
   localparam logic [1:0] NpcJr     = 2'b11;

   // Register-file write address select
   localparam logic [1:0] WrselRt = 2'b00;
   localparam logic [1:0] WrselRd = 2'b01;
   localparam logic [1:0] WrselRa = 2'b11;

   // Register-file write data select
   localparam logic [1:0] WdselAlu = 2'b00;
   localparam logic [1:0] WdselDm  = 2'b01;
   localparam logic [1:0] WdselPc4 = 2'b10;

   // ALU operation
   localparam logic [2:0] AluAdd = 3'b000;
   localparam logic [2:0] AluSub = 3'b001;
   localparam logic [2:0] AluOr  = 3'b010;
   localparam logic [2:0] AluLui = 3'b011;

   // Data-memory access type and size
   localparam logic [1:0] DmwrNone  = 2'b00;
   localparam logic [1:0] DmwrLoad  = 2'b01;
   localparam logic [1:0] DmwrStore = 2'b10;
   localparam logic [1:0] DmselWord = 2'b00;
   localparam logic [1:0] DmselHalf = 2'b01;
   localparam logic [1:0] DmselByte = 2'b10;

   // Bit positions of the one-hot instruction-class vector
   localparam int unsigned NumInstr = 16;
   localparam int unsigned IAdd     = 0;
   localparam int unsigned ISub     = 1;
   localparam int unsigned IJr      = 2;
   localparam int unsigned IOri     = 3;
   localparam int unsigned ILui     = 4;
   localparam int unsigned ILw      = 5;
   localparam int unsigned ILh      = 6;
   localparam int unsigned ILb      = 7;
   localparam int unsigned ISw      = 8;
   localparam int unsigned ISh      = 9;
   localparam int unsigned ISb      = 10;
   localparam int unsigned IBeq     = 11;
   localparam int unsigned IBltzal  = 12;
   localparam int unsigned IJ       = 13;
   localparam int unsigned IJal     = 14;
   localparam int unsigned IIllegal = 15;

   function automatic logic is_load(input logic [NumInstr-1:0] oh);
      return oh[ILw] | oh[ILh] | oh[ILb];
   endfunction

   function automatic logic is_store(input logic [NumInstr-1:0] oh);
      return oh[ISw] | oh[ISh] | oh[ISb];
   endfunction

   // Access size shared by the load and store of the same width
   function automatic logic [1:0] dm_size(input logic [NumInstr-1:0] oh);
      if (oh[ILb] | oh[ISb]) return DmselByte;
      if (oh[ILh] | oh[ISh]) return DmselHalf;
      return DmselWord;
   endfunction

endpackage

// File: rtl/mc_decode.sv
// mc_decode: combinational opcode/funct to one-hot instruction-class decoder.
// Exactly one bit of instr is set; anything unsupported lands on IIllegal.
module mc_decode
   import mc_pkg::*;
(
   input  logic [5:0]          opcode,
   input  logic [5:0]          funct,
   output logic [NumInstr-1:0] instr
);

   // Classify the instruction held in the IR
   always_comb begin
      instr = '0;
      unique case (opcode)
         OpSpecial: begin
            unique case (funct)
               FnAdd:   instr[IAdd]     = 1'b1;
               FnSub:   instr[ISub]     = 1'b1;
               FnJr:    instr[IJr]      = 1'b1;
               default: instr[IIllegal] = 1'b1;
            endcase
         end
         OpOri:    instr[IOri]     = 1'b1;
         OpLui:    instr[ILui]     = 1'b1;
         OpLw:     instr[ILw]      = 1'b1;
         OpLh:     instr[ILh]      = 1'b1;
         OpLb:     instr[ILb]      = 1'b1;
         OpSw:     instr[ISw]      = 1'b1;
         OpSh:     instr[ISh]      = 1'b1;
         OpSb:     instr[ISb]      = 1'b1;
         OpBeq:    instr[IBeq]     = 1'b1;
         OpBltzal: instr[IBltzal]  = 1'b1;
         OpJ:      instr[IJ]       = 1'b1;
         OpJal:    instr[IJal]     = 1'b1;
         default:  instr[IIllegal] = 1'b1;
      endcase
   end

endmodule

// File: rtl/mc_control.sv
// mc_control: five-state multi-cycle sequencer (FETCH, DECODE, EXEC, MEM, WB) for the
// MIPS-subset datapath. Write enables are single-cycle pulses; selects are zero whenever
// they are not in use. Memory waits are bounded by TIMEOUT (0 = unbounded).
// Optional build macro PERF_CNT_EN adds cycle_cnt / instr_cnt performance counters.
module mc_control
   import mc_pkg::*;
#(
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned CNT_W   = 5   // must satisfy 2**CNT_W > TIMEOUT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [5:0]  opcode,
   input  logic [5:0]  funct,
   input  logic        branch,
   input  logic        imem_ready,
   input  logic        dmem_ready,
   output logic        imem_req,
   output logic        dmem_req,
   output logic        IRWr,
   output logic        PCWr,
   output logic [1:0]  NPCop,
   output logic [1:0]  WRsel,
   output logic [1:0]  WDsel,
   output logic        RFWr,
   output logic        EXTop,
   output logic        Bsel,
   output logic [2:0]  ALUop,
   output logic [1:0]  DMWr,
   output logic [1:0]  DMsel,
   output logic [2:0]  state,
   output logic        illegal,
   output logic        timeout
`ifdef PERF_CNT_EN
   ,
   output logic [31:0] cycle_cnt,
   output logic [31:0] instr_cnt
`endif
);

   state_e               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 illegal_q, illegal_d;
   logic                 timeout_q, timeout_d;
   logic [NumInstr-1:0]  instr;
   logic                 ld, st, rtype;
   logic                 wait_hit;

   mc_decode u_decode (
      .opcode (opcode),
      .funct  (funct),
      .instr  (instr)
   );

   assign ld    = is_load(instr);
   assign st    = is_store(instr);
   assign rtype = instr[IAdd] | instr[ISub];

   // The wait limit is evaluated on the cycle the counter already holds TIMEOUT, so a
   // ready arriving on that same cycle still completes the access.
   assign wait_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT));

   // State, wait counter and sticky flags
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= StFetch;
         cnt_q     <= '0;
         illegal_q <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         illegal_q <= illegal_d;
         timeout_q <= timeout_d;
      end
   end

   // Next state and per-state datapath controls
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      illegal_d = illegal_q;
      timeout_d = timeout_q;
      imem_req  = 1'b0;
      dmem_req  = 1'b0;
      IRWr      = 1'b0;
      PCWr      = 1'b0;
      NPCop     = NpcPc4;
      WRsel     = WrselRt;
      WDsel     = WdselAlu;
      RFWr      = 1'b0;
      EXTop     = 1'b0;
      Bsel      = 1'b0;
      ALUop     = AluAdd;
      DMWr      = DmwrNone;
      DMsel     = DmselWord;

      unique case (state_q)
         StFetch: begin
            imem_req = 1'b1;
            if (imem_ready) begin
               IRWr    = 1'b1;
               PCWr    = 1'b1;
               NPCop   = NpcPc4;
               state_d = StDecode;
            end else if (wait_hit) begin
               // Give up on this attempt and re-issue the fetch
               timeout_d = 1'b1;
               cnt_d     = '0;
            end else if (TIMEOUT != 0) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         StDecode: begin
            if (instr[IJ]) begin
               PCWr    = 1'b1;
               NPCop   = NpcJump;
               state_d = StFetch;
            end else if (instr[IJal]) begin
               PCWr    = 1'b1;
               NPCop   = NpcJump;
               RFWr    = 1'b1;
               WRsel   = WrselRa;
               WDsel   = WdselPc4;
               state_d = StFetch;
            end else if (instr[IJr]) begin
               PCWr    = 1'b1;
               NPCop   = NpcJr;
               state_d = StFetch;
            end else if (instr[IIllegal]) begin
               // Unsupported encoding retires as a nop
               illegal_d = 1'b1;
               state_d   = StFetch;
            end else begin
               state_d = StExec;
            end
         end

         StExec: begin
            if (ld || st) begin
               ALUop   = AluAdd;
               Bsel    = 1'b1;
               EXTop   = 1'b1;
               state_d = StMem;
            end else if (instr[IOri]) begin
               ALUop   = AluOr;
               Bsel    = 1'b1;
               state_d = StWb;
            end else if (instr[ILui]) begin
               ALUop   = AluLui;
               Bsel    = 1'b1;
               state_d = StWb;
            end else if (instr[ISub]) begin
               ALUop   = AluSub;
               state_d = StWb;
            end else if (instr[IAdd]) begin
               ALUop   = AluAdd;
               state_d = StWb;
            end else if (instr[IBeq]) begin
               ALUop   = AluSub;
               EXTop   = 1'b1;
               PCWr    = branch;
               NPCop   = branch ? NpcBranch : NpcPc4;
               state_d = StFetch;
            end else if (instr[IBltzal]) begin
               PCWr = branch;
               RFWr = branch;
               if (branch) begin
                  NPCop = NpcBranch;
                  WRsel = WrselRa;
                  WDsel = WdselPc4;
               end
               state_d = StFetch;
            end else begin
               // Only reachable if the IR changes after DECODE; recover by refetching
               state_d = StFetch;
            end
         end

         StMem: begin
            dmem_req = 1'b1;
            DMWr     = st ? DmwrStore : DmwrLoad;
            DMsel    = dm_size(instr);
            if (dmem_ready) begin
               state_d = st ? StFetch : StWb;
            end else if (wait_hit) begin
               // Abort: no write-back for a timed-out load
               timeout_d = 1'b1;
               state_d   = StFetch;
            end else if (TIMEOUT != 0) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         StWb: begin
            RFWr    = 1'b1;
            WRsel   = rtype ? WrselRd : WrselRt;
            WDsel   = ld ? WdselDm : WdselAlu;
            state_d = StFetch;
         end

         default: begin
            state_d = StFetch;
         end
      endcase

      if (state_d != state_q) begin
         cnt_d = '0;
      end

      // Outputs are forced low for the whole reset window, including the fetch request
      if (reset) begin
         imem_req = 1'b0;
         dmem_req = 1'b0;
         IRWr     = 1'b0;
         PCWr     = 1'b0;
         NPCop    = NpcPc4;
         WRsel    = WrselRt;
         WDsel    = WdselAlu;
         RFWr     = 1'b0;
         EXTop    = 1'b0;
         Bsel     = 1'b0;
         ALUop    = AluAdd;
         DMWr     = DmwrNone;
         DMsel    = DmselWord;
      end
   end

   assign state   = state_q;
   assign illegal = illegal_q;
   assign timeout = timeout_q;

`ifdef PERF_CNT_EN
   // Free-running cycle count and retired-instruction count (every return to FETCH)
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cycle_cnt <= '0;
         instr_cnt <= '0;
      end else begin
         cycle_cnt <= cycle_cnt + 32'd1;
         if ((state_q != StFetch) && (state_d == StFetch)) begin
            instr_cnt <= instr_cnt + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control: directed, self-checking bench for mc_control. Two instances share the
// stimulus: dut uses the default TIMEOUT, dut_to uses TIMEOUT=4 for the wait-limit cases.
module tb_mc_control;
   import mc_pkg::*;

   typedef struct packed {
      logic [2:0] st;
      logic       imem;
      logic       dmem;
      logic       irwr;
      logic       pcwr;
      logic [1:0] npc;
      logic [1:0] wrsel;
      logic [1:0] wdsel;
      logic       rfwr;
      logic       ext;
      logic       bsel;
      logic [2:0] alu;
      logic [1:0] dmwr;
      logic [1:0] dmsel;
   } obs_t;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] opcode, funct;
   logic       branch, imem_ready, dmem_ready;

   logic       imem_req, dmem_req, IRWr, PCWr, RFWr, EXTop, Bsel, illegal, timeout;
   logic [1:0] NPCop, WRsel, WDsel, DMWr, DMsel;
   logic [2:0] ALUop, state;
   logic       t_imem_req, t_dmem_req, t_IRWr, t_PCWr, t_RFWr, t_EXTop, t_Bsel;
   logic       t_illegal, t_timeout;
   logic [1:0] t_NPCop, t_WRsel, t_WDsel, t_DMWr, t_DMsel;
   logic [2:0] t_ALUop, t_state;
`ifdef PERF_CNT_EN
   logic [31:0] cycle_cnt, instr_cnt, t_cycle_cnt, t_instr_cnt;
`endif

   obs_t obs, tobs, fgo, fwait, dnone;
   int   n_checks = 0;
   int   n_err    = 0;

   always #5 clk = ~clk;

   mc_control dut (
      .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .branch(branch),
      .imem_ready(imem_ready), .dmem_ready(dmem_ready), .imem_req(imem_req),
      .dmem_req(dmem_req), .IRWr(IRWr), .PCWr(PCWr), .NPCop(NPCop), .WRsel(WRsel),
      .WDsel(WDsel), .RFWr(RFWr), .EXTop(EXTop), .Bsel(Bsel), .ALUop(ALUop), .DMWr(DMWr),
      .DMsel(DMsel), .state(state), .illegal(illegal), .timeout(timeout)
`ifdef PERF_CNT_EN
      , .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
`endif
   );

   mc_control #(.TIMEOUT(4), .CNT_W(5)) dut_to (
      .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .branch(branch),
      .imem_ready(imem_ready), .dmem_ready(dmem_ready), .imem_req(t_imem_req),
      .dmem_req(t_dmem_req), .IRWr(t_IRWr), .PCWr(t_PCWr), .NPCop(t_NPCop),
      .WRsel(t_WRsel), .WDsel(t_WDsel), .RFWr(t_RFWr), .EXTop(t_EXTop), .Bsel(t_Bsel),
      .ALUop(t_ALUop), .DMWr(t_DMWr), .DMsel(t_DMsel), .state(t_state),
      .illegal(t_illegal), .timeout(t_timeout)
`ifdef PERF_CNT_EN
      , .cycle_cnt(t_cycle_cnt), .instr_cnt(t_instr_cnt)
`endif
   );

   assign obs  = {state, imem_req, dmem_req, IRWr, PCWr, NPCop, WRsel, WDsel, RFWr, EXTop,
                  Bsel, ALUop, DMWr, DMsel};
   assign tobs = {t_state, t_imem_req, t_dmem_req, t_IRWr, t_PCWr, t_NPCop, t_WRsel,
                  t_WDsel, t_RFWr, t_EXTop, t_Bsel, t_ALUop, t_DMWr, t_DMsel};

   // Expected-output builder, argument order matches obs_t
   function automatic obs_t mk(input int st, input int imem, input int dmem, input int irwr,
                               input int pcwr, input int npc, input int wrsel, input int wdsel,
                               input int rfwr, input int ext, input int bsel, input int alu,
                               input int dmwr, input int dmsel);
      obs_t r;
      r.st = 3'(st);      r.imem = 1'(imem);   r.dmem = 1'(dmem);   r.irwr = 1'(irwr);
      r.pcwr = 1'(pcwr);  r.npc = 2'(npc);     r.wrsel = 2'(wrsel); r.wdsel = 2'(wdsel);
      r.rfwr = 1'(rfwr);  r.ext = 1'(ext);     r.bsel = 1'(bsel);   r.alu = 3'(alu);
      r.dmwr = 2'(dmwr);  r.dmsel = 2'(dmsel);
      return r;
   endfunction

   // Leaves reset released at a falling edge with the FSM in FETCH
   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1; imem_ready = 1'b0; dmem_ready = 1'b0; branch = 1'b0;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; imem_ready = 1'b1; dmem_ready = 1'b1; branch = 1'b1;
      opcode = OpJal; funct = 6'h00;
      @(negedge clk);
      #1;
      n_checks++;
      if (obs !== obs_t'(0)) begin
         n_err++; $display("FAIL reset_outputs: got %h want %h", obs, obs_t'(0));
      end
      n_checks++;
      if (tobs !== obs_t'(0)) begin
         n_err++; $display("FAIL reset_outputs_to: got %h want %h", tobs, obs_t'(0));
      end
      n_checks++;
      if ({illegal, timeout} !== 2'b00) begin
         n_err++; $display("FAIL reset_flags: got %b want 00", {illegal, timeout});
      end
      @(negedge clk);
      reset = 1'b0; imem_ready = 1'b0;
      #1;
      n_checks++;
      if (obs !== fwait) begin
         n_err++; $display("FAIL reset_release: got %h want %h", obs, fwait);
      end
   endtask

   task automatic test_ori();
      obs_t ex[5];
      do_reset();
      opcode = OpOri; funct = 6'h00;
      ex[0] = fgo;
      ex[1] = dnone;
      ex[2] = mk(StExec, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, AluOr, 0, 0);
      ex[3] = mk(StWb, 0, 0, 0, 0, 0, WrselRt, WdselAlu, 1, 0, 0, 0, 0, 0);
      ex[4] = fwait;
      for (int i = 0; i < 5; i++) begin
         imem_ready = (i == 0);
         #1;
         n_checks++;
         if (obs !== ex[i]) begin
            n_err++; $display("FAIL ori c%0d: got %h want %h", i, obs, ex[i]);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_rtype();
      obs_t ex[5];
      for (int k = 0; k < 2; k++) begin
         do_reset();
         opcode = OpSpecial; funct = (k == 0) ? FnAdd : FnSub;
         ex[0] = fgo;
         ex[1] = dnone;
         ex[2] = mk(StExec, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, (k == 0) ? AluAdd : AluSub, 0, 0);
         ex[3] = mk(StWb, 0, 0, 0, 0, 0, WrselRd, WdselAlu, 1, 0, 0, 0, 0, 0);
         ex[4] = fwait;
         for (int i = 0; i < 5; i++) begin
            imem_ready = (i == 0);
            #1;
            n_checks++;
            if (obs !== ex[i]) begin
               n_err++; $display("FAIL rtype%0d c%0d: got %h want %h", k, i, obs, ex[i]);
            end
            @(negedge clk);
         end
      end
   endtask

   task automatic test_lw_wait();
      obs_t ex[9];
      do_reset();
      opcode = OpLw; funct = 6'h00;
      ex[0] = fgo;
      ex[1] = dnone;
      ex[2] = mk(StExec, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, AluAdd, 0, 0);
      for (int i = 3; i < 7; i++) ex[i] = mk(StMem, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                                              DmwrLoad, DmselWord);
      ex[7] = mk(StWb, 0, 0, 0, 0, 0, WrselRt, WdselDm, 1, 0, 0, 0, 0, 0);
      ex[8] = fwait;
      for (int i = 0; i < 9; i++) begin
         imem_ready = (i == 0);
         dmem_ready = (i == 6);
         #1;
         n_checks++;
         if (obs !== ex[i]) begin
            n_err++; $display("FAIL lw_wait c%0d: got %h want %h", i, obs, ex[i]);
         end
         @(negedge clk);
      end
      dmem_ready = 1'b0;
   endtask

   task automatic test_branches();
      obs_t ex[4];
      // k=0,1: beq taken / not taken; k=2,3: bltzal taken / not taken
      for (int k = 0; k < 4; k++) begin
         int b;
         b = (k % 2 == 0) ? 1 : 0;
         do_reset();
         opcode = (k < 2) ? OpBeq : OpBltzal; funct = 6'h00;
         ex[0] = fgo;
         ex[1] = dnone;
         if (k < 2)
            ex[2] = mk(StExec, 0, 0, 0, b, b ? NpcBranch : NpcPc4, 0, 0, 0, 1, 0, AluSub, 0, 0);
         else
            ex[2] = b ? mk(StExec, 0, 0, 0, 1, NpcBranch, WrselRa, WdselPc4, 1, 0, 0, 0, 0, 0)
                      : mk(StExec, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
         ex[3] = fwait;
         for (int i = 0; i < 4; i++) begin
            imem_ready = (i == 0);
            branch     = 1'(b);
            #1;
            n_checks++;
            if (obs !== ex[i]) begin
               n_err++; $display("FAIL branch%0d c%0d: got %h want %h", k, i, obs, ex[i]);
            end
            @(negedge clk);
         end
      end
      branch = 1'b0;
   endtask

   task automatic test_jumps();
      logic [5:0] ops[3];
      logic [5:0] fns[3];
      obs_t       dx[3];
      obs_t       ex;
      ops[0] = OpJ;       fns[0] = 6'h00;
      ops[1] = OpJal;     fns[1] = 6'h00;
      ops[2] = OpSpecial; fns[2] = FnJr;
      dx[0] = mk(StDecode, 0, 0, 0, 1, NpcJump, 0, 0, 0, 0, 0, 0, 0, 0);
      dx[1] = mk(StDecode, 0, 0, 0, 1, NpcJump, WrselRa, WdselPc4, 1, 0, 0, 0, 0, 0);
      dx[2] = mk(StDecode, 0, 0, 0, 1, NpcJr, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int k = 0; k < 3; k++) begin
         do_reset();
         opcode = ops[k]; funct = fns[k];
         for (int i = 0; i < 3; i++) begin
            imem_ready = (i == 0);
            ex = (i == 0) ? fgo : (i == 1) ? dx[k] : fwait;
            #1;
            n_checks++;
            if (obs !== ex) begin
               n_err++; $display("FAIL jump%0d c%0d: got %h want %h", k, i, obs, ex);
            end
            @(negedge clk);
         end
      end
   endtask

   task automatic test_illegal();
      obs_t ex;
      // k=0: bad opcode, k=1: SPECIAL with bad funct
      for (int k = 0; k < 2; k++) begin
         do_reset();
         opcode = (k == 0) ? 6'h3f : OpSpecial; funct = 6'h3f;
         for (int i = 0; i < 3; i++) begin
            imem_ready = (i == 0);
            ex = (i == 0) ? fgo : (i == 1) ? dnone : fwait;
            #1;
            n_checks++;
            if (obs !== ex) begin
               n_err++; $display("FAIL illegal%0d c%0d: got %h want %h", k, i, obs, ex);
            end
            n_checks++;
            if (illegal !== (i == 2)) begin
               n_err++; $display("FAIL illegal_flag%0d c%0d: got %b want %b", k, i, illegal,
                                 (i == 2));
            end
            @(negedge clk);
         end
      end
   endtask

   task automatic test_mem_timeout();
      obs_t ex[9];
      do_reset();
      opcode = OpSw; funct = 6'h00;
      ex[0] = fgo;
      ex[1] = dnone;
      ex[2] = mk(StExec, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, AluAdd, 0, 0);
      for (int i = 3; i < 8; i++) ex[i] = mk(StMem, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                                              DmwrStore, DmselWord);
      ex[8] = fwait;
      for (int i = 0; i < 9; i++) begin
         imem_ready = (i == 0);
         #1;
         n_checks++;
         if (tobs !== ex[i]) begin
            n_err++; $display("FAIL mem_timeout c%0d: got %h want %h", i, tobs, ex[i]);
         end
         if (i >= 7) begin
            n_checks++;
            if (t_timeout !== (i == 8)) begin
               n_err++; $display("FAIL mem_timeout_flag c%0d: got %b want %b", i, t_timeout,
                                 (i == 8));
            end
         end
         @(negedge clk);
      end
   endtask

   task automatic test_fetch_timeout();
      // Ready on the limit cycle wins: fetch proceeds, no timeout
      do_reset();
      opcode = OpOri; funct = 6'h00;
      for (int i = 0; i < 6; i++) begin
         imem_ready = (i == 4);
         #1;
         n_checks++;
         if (tobs !== ((i < 4) ? fwait : (i == 4) ? fgo : dnone)) begin
            n_err++; $display("FAIL fetch_ready_wins c%0d: got %h", i, tobs);
         end
         @(negedge clk);
      end
      n_checks++;
      if (t_timeout !== 1'b0) begin
         n_err++; $display("FAIL fetch_ready_wins_flag: got %b want 0", t_timeout);
      end
      // No ready: timeout after the limit, request re-issued from FETCH
      do_reset();
      for (int i = 0; i < 7; i++) begin
         imem_ready = (i == 6);
         #1;
         n_checks++;
         if (tobs !== ((i == 6) ? fgo : fwait)) begin
            n_err++; $display("FAIL fetch_timeout c%0d: got %h", i, tobs);
         end
         n_checks++;
         if (t_timeout !== (i >= 5)) begin
            n_err++; $display("FAIL fetch_timeout_flag c%0d: got %b want %b", i, t_timeout,
                              (i >= 5));
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset_mid();
      obs_t ex;
      do_reset();
      // Illegal first so a sticky flag is set before the mid-access reset
      opcode = 6'h3f; funct = 6'h00;
      imem_ready = 1'b1;
      @(negedge clk);
      imem_ready = 1'b0;
      @(negedge clk);
      opcode = OpSb;
      for (int i = 0; i < 5; i++) begin
         imem_ready = (i == 0);
         ex = (i == 0) ? fgo : (i == 1) ? dnone :
              (i == 2) ? mk(StExec, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, AluAdd, 0, 0) :
                         mk(StMem, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, DmwrStore, DmselByte);
         #1;
         n_checks++;
         if (obs !== ex) begin
            n_err++; $display("FAIL sb c%0d: got %h want %h", i, obs, ex);
         end
         @(negedge clk);
      end
      n_checks++;
      if (illegal !== 1'b1) begin
         n_err++; $display("FAIL sb_illegal_before: got %b want 1", illegal);
      end
      reset = 1'b1;
      #1;
      n_checks++;
      if (obs !== obs_t'(0)) begin
         n_err++; $display("FAIL reset_mid_outputs: got %h want %h", obs, obs_t'(0));
      end
      n_checks++;
      if ({illegal, timeout} !== 2'b00) begin
         n_err++; $display("FAIL reset_mid_flags: got %b want 00", {illegal, timeout});
      end
      @(negedge clk);
      reset = 1'b0;
      #1;
      n_checks++;
      if (obs !== fwait) begin
         n_err++; $display("FAIL reset_mid_release: got %h want %h", obs, fwait);
      end
   endtask

   initial begin
      fgo   = mk(StFetch, 1, 0, 1, 1, NpcPc4, 0, 0, 0, 0, 0, 0, 0, 0);
      fwait = mk(StFetch, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      dnone = mk(StDecode, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      test_reset();
      test_ori();
      test_rtype();
      test_lw_wait();
      test_branches();
      test_jumps();
      test_illegal();
      test_mem_timeout();
      test_fetch_timeout();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1);
   end

endmodule

// File: doc/mc_control.md
Name: mc_control

Overview:
Multi-cycle sequencer for the MIPS-subset datapath. It replaces per-instruction combinational decode with a 5-state FSM: FETCH, DECODE, EXEC, MEM, WB. Each instruction's datapath selects are driven in the state that needs them, and every write enable is a single-cycle pulse. It handshakes with instruction and data memories that may insert wait states.

Parameters:
- TIMEOUT, 16, max consecutive wait cycles allowed in FETCH or MEM before the access is aborted; 0 disables the timeout.
- CNT_W, 5, width of the wait counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- opcode  in  6  IR[31:26]; valid from DECODE onward.
- funct  in  6  IR[5:0].
- branch  in  1  branch condition from the datapath (beq equal / bltzal negative).
- imem_ready  in  1  instruction memory done.
- dmem_ready  in  1  data memory done.
- imem_req  out  1  instruction fetch request.
- dmem_req  out  1  data access request.
- IRWr  out  1  IR load.
- PCWr  out  1  PC load.
- NPCop  out  2  00 PC+4, 01 branch, 10 j/jal, 11 jr.
- WRsel  out  2  00 rt, 01 rd, 11 $31.
- WDsel  out  2  00 ALU, 01 DM, 10 PC+4.
- RFWr  out  1  register write.
- EXTop  out  1  1 = sign-extend.
- Bsel  out  1  1 = immediate operand.
- ALUop  out  3  000 add, 001 sub, 010 or, 011 lui.
- DMWr  out  2  10 store, 01 load, 00 none.
- DMsel  out  2  00 word, 01 half, 10 byte.
- state  out  3  current state: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4.
- illegal  out  1  sticky: an unsupported opcode/funct was decoded.
- timeout  out  1  sticky: a memory wait exceeded TIMEOUT.

Behaviour:
- Reset (asynchronous): state=FETCH; wait counter, illegal and timeout cleared. While reset is high all outputs are 0, including imem_req.
- Supported instructions: add, sub, jr, ori, lui, lw, lh, lb, sw, sh, sb, beq, bltzal, j, jal.
- FETCH: imem_req=1. When imem_ready: IRWr=1, PCWr=1, NPCop=00, go to DECODE. Otherwise stay and increment the wait counter.
- DECODE (one cycle):
  - j: PCWr=1, NPCop=10, go to FETCH.
  - jal: PCWr=1, NPCop=10, RFWr=1, WRsel=11, WDsel=10, go to FETCH.
  - jr: PCWr=1, NPCop=11, go to FETCH.
  - illegal opcode/funct: set illegal, treat as nop, go to FETCH.
  - all others: go to EXEC.
- EXEC:
  - Drive ALUop/Bsel/EXTop as follows: ori ALUop=010, Bsel=1; lui ALUop=011, Bsel=1; sub/beq ALUop=001; loads/stores add with Bsel=1, EXTop=1; beq EXTop=1.
  - beq: PCWr=branch, NPCop=01, go to FETCH.
  - bltzal: PCWr=branch, RFWr=branch, WRsel=11, WDsel=10, NPCop=01, go to FETCH.
  - add/sub/ori/lui: go to WB.
  - loads/stores: go to MEM.
- MEM: dmem_req=1; DMWr and DMsel held for the whole access. When dmem_ready: a store goes to FETCH, a load goes to WB. Otherwise wait.
- WB: RFWr=1; WRsel=01 for R-type, 00 otherwise; WDsel=01 for loads, 00 otherwise; go to FETCH.
- Latency with zero-wait memory, in cycles: j/jal/jr 2; beq/bltzal 3; ALU ops 4; stores 4; loads 5.
- Enable rules:
  - IRWr, PCWr and RFWr are pulses of at most one cycle per instruction.
  - DMWr is nonzero only in MEM.
  - Selects are don't-care when their enable is low, but must be driven to 0.
- Wait counter:
  - Cleared on every state change.
  - When TIMEOUT≠0 and the counter reaches TIMEOUT in FETCH: set timeout, re-issue the request (stay in FETCH), clear the counter.
  - Same condition in MEM: set timeout, abort the access with no RFWr, go to FETCH.
- A ready signal arriving in the same cycle the timeout is reached: ready wins and timeout is not set.
- Ready signals are ignored outside their own state.
- Reset asserted mid-instruction: pending enables drop immediately; no partial RF or DM write.

Optional Feature:
PERF_CNT_EN
- Defined: adds output ports cycle_cnt[31:0] and instr_cnt[31:0], both reset to 0.
  - cycle_cnt increments every cycle outside reset.
  - instr_cnt increments on every transition into FETCH from DECODE, EXEC, MEM or WB, including illegal-instruction nops and aborted accesses.
  - Both counters wrap at 2^32.
- Undefined: these ports and counters are absent.

Decomposition:
- Package mc_pkg holds:
  - state encoding constants;
  - opcode constants (SPECIAL 000000, ORI 001101, LW 100011, SW 101011, BEQ 000100, LUI 001111, J 000010, JAL 000011, LB 100000, LH 100001, SB 101000, SH 101001, BLTZAL 000001);
  - funct constants (ADD 100000, SUB 100010, JR 001000);
  - NPCop/WRsel/WDsel/ALUop/DMWr/DMsel encodings.
- Sub-module mc_decode: purely combinational opcode/funct to one-hot instruction-class decoder. The FSM in mc_control consumes its outputs.

Test Plan:
- ori $t0,$0,0x1234 with zero-wait memory → states 0,1,2,4,0; RFWr pulses only in WB with Bsel=1, ALUop=010, WRsel=00.
- lw with dmem_ready delayed 3 cycles → dmem_req high for 4 cycles with DMWr=01 throughout; then WB with WDsel=01; 8 cycles total.
- beq with branch=1, then with branch=0 → PCWr/NPCop=01 in EXEC only when branch=1; 3 cycles each; RFWr never asserted.
- jal, then opcode 111111 → jal: RFWr=1, WRsel=11, WDsel=10, PCWr=1 in DECODE. 111111: illegal=1, no enable pulses, return to FETCH.
- TIMEOUT=4, dmem_ready never asserted for sw → timeout=1 after 4 wait cycles, DMWr drops, state=FETCH.
- Reset pulsed while in MEM for sb → all outputs 0 immediately; after release state=FETCH, imem_req=1, flags 0.
